// File: rtl/regfile_pkg.sv
// regfile_pkg: constants shared by the register file, its read ports and its interface.
//
// Optional build macro (used by regfile_read_port):
//   REGFILE_BYPASS_EN - same-cycle write-through bypass on every read port.
//
// Contents:
//   REG_DATA_W / REG_ADDR_W - default entry width and address width
//   REG_ZERO_ADDR           - hard-wired zero register
//   REG_NUM_RD              - default number of read ports
//   REG_INIT_ZERO / REG_INIT_INDEX - encodings for the INIT_INDEX parameter

package regfile_pkg;

  localparam int unsigned REG_DATA_W    = 32;
  localparam int unsigned REG_ADDR_W    = 5;
  localparam int unsigned REG_ZERO_ADDR = 0;
  localparam int unsigned REG_NUM_RD    = 2;

  // INIT_INDEX encodings: every entry resets to 0, or entry i resets to i.
  localparam int unsigned REG_INIT_ZERO  = 0;
  localparam int unsigned REG_INIT_INDEX = 1;

endpackage : regfile_pkg

// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if: bundles the decode/writeback-facing signals of the register file.
//
// Signals:
//   rd_addr  [NUM_RD*ADDR_W] read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data  [NUM_RD*DATA_W] read data, port k at [k*DATA_W +: DATA_W]
//   rd_busy  [NUM_RD]        busy bit of the addressed register, per port
//   we / wr_addr / wr_data   writeback write port
//   rsv_en / rsv_addr        decode reserve of a destination register
//   busy_vec [DEPTH]         full scoreboard
// Modports:
//   master - pipeline side (drives addresses, writes, reserves)
//   slave  - register file side

interface regfile_scoreboard_if
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = REG_DATA_W,
  parameter int unsigned ADDR_W = REG_ADDR_W,
  parameter int unsigned NUM_RD = REG_NUM_RD
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     we;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;
  logic [DEPTH-1:0]         busy_vec;

  modport master (
    output rd_addr,
    output we,
    output wr_addr,
    output wr_data,
    output rsv_en,
    output rsv_addr,
    input  rd_data,
    input  rd_busy,
    input  busy_vec
  );

  modport slave (
    input  rd_addr,
    input  we,
    input  wr_addr,
    input  wr_data,
    input  rsv_en,
    input  rsv_addr,
    output rd_data,
    output rd_busy,
    output busy_vec
  );

endinterface : regfile_scoreboard_if

// File: rtl/regfile_read_port.sv
// regfile_read_port: one combinational read port of the register file.
//
// Selects the addressed entry and its busy bit, forces register 0 to zero / not busy and,
// when built with REGFILE_BYPASS_EN, forwards a same-cycle writeback to this port.
//
// Ports:
//   rd_addr_i  read address
//   mem_i      whole register array (registered)
//   busy_i     whole scoreboard (registered)
//   we_i, wr_addr_i, wr_data_i  writeback in flight this cycle (bypass source)
//   rsv_en_i, rsv_addr_i        reserve in flight this cycle (bypass busy override)
//   rd_data_o  read data
//   rd_busy_o  busy bit of the addressed register

module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = REG_DATA_W,
  parameter int unsigned ADDR_W = REG_ADDR_W
) (
  input  logic [ADDR_W-1:0]                   rd_addr_i,
  input  logic [2**ADDR_W-1:0][DATA_W-1:0]    mem_i,
  input  logic [2**ADDR_W-1:0]                busy_i,
  input  logic                                we_i,
  input  logic [ADDR_W-1:0]                   wr_addr_i,
  input  logic [DATA_W-1:0]                   wr_data_i,
  input  logic                                rsv_en_i,
  input  logic [ADDR_W-1:0]                   rsv_addr_i,
  output logic [DATA_W-1:0]                   rd_data_o,
  output logic                                rd_busy_o
);

  localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(REG_ZERO_ADDR);

  logic byp_hit;
  logic byp_busy;

`ifdef REGFILE_BYPASS_EN
  // A writeback to the address being read is forwarded; it also retires the producer unless
  // decode reserves the same register on this very edge.
  assign byp_hit  = we_i && (wr_addr_i == rd_addr_i);
  assign byp_busy = rsv_en_i && (rsv_addr_i == rd_addr_i);
`else
  assign byp_hit  = 1'b0;
  assign byp_busy = 1'b0;

  logic unused_byp;
  assign unused_byp = ^{we_i, wr_addr_i, wr_data_i, rsv_en_i, rsv_addr_i};
`endif

  always_comb begin
    rd_data_o = mem_i[rd_addr_i];
    rd_busy_o = busy_i[rd_addr_i];
    if (byp_hit) begin
      rd_data_o = wr_data_i;
      rd_busy_o = byp_busy;
    end
    // Register 0 wins over everything, including the bypass.
    if (rd_addr_i == ZeroAddr) begin
      rd_data_o = '0;
      rd_busy_o = 1'b0;
    end
  end

endmodule : regfile_read_port

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: integer register file with a per-register busy scoreboard.
//
// DEPTH = 2**ADDR_W entries of DATA_W bits, NUM_RD combinational read ports, one write port.
// Decode reserves a destination (busy set); writeback writes it (busy cleared). Register 0 is
// hard-wired to zero and never busy. Optional macro REGFILE_BYPASS_EN enables a same-cycle
// write-through bypass in every read port.
//
// Ports:
//   clk  clock, all state updates on the rising edge
//   rst  synchronous active-high reset: array loads its INIT_INDEX values, busy bits clear
//   bus  regfile_scoreboard_if.slave: read ports, write port, reserve port, busy_vec

module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W     = REG_DATA_W,
  parameter int unsigned ADDR_W     = REG_ADDR_W,
  parameter int unsigned NUM_RD     = REG_NUM_RD,
  parameter int unsigned INIT_INDEX = REG_INIT_INDEX
) (
  input logic                 clk,
  input logic                 rst,
  regfile_scoreboard_if.slave bus
);

  localparam int unsigned       DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(REG_ZERO_ADDR);

  logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d, mem_rst;
  logic [DEPTH-1:0]             busy_q, busy_d;
  logic                         wr_ok, rsv_ok;

  // Reset image: entry i holds i (entry 0 is 0 either way) or everything is 0.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem_rst[i] = (INIT_INDEX == REG_INIT_INDEX) ? DATA_W'(i) : '0;
    end
  end

  assign wr_ok  = bus.we && (bus.wr_addr != ZeroAddr);
  assign rsv_ok = bus.rsv_en && (bus.rsv_addr != ZeroAddr);

  // Write first, then reserve: on a same-address collision the new producer keeps the
  // register busy while the older producer's data still lands.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    if (wr_ok) begin
      mem_d[bus.wr_addr]  = bus.wr_data;
      busy_d[bus.wr_addr] = 1'b0;
    end
    if (rsv_ok) begin
      busy_d[bus.rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q  <= mem_rst;
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  assign bus.busy_vec = busy_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_port
    regfile_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_rd_port (
      .rd_addr_i  (bus.rd_addr[k*ADDR_W +: ADDR_W]),
      .mem_i      (mem_q),
      .busy_i     (busy_q),
      .we_i       (bus.we),
      .wr_addr_i  (bus.wr_addr),
      .wr_data_i  (bus.wr_data),
      .rsv_en_i   (bus.rsv_en),
      .rsv_addr_i (bus.rsv_addr),
      .rd_data_o  (bus.rd_data[k*DATA_W +: DATA_W]),
      .rd_busy_o  (bus.rd_busy[k])
    );
  end

endmodule : regfile_scoreboard

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised, clocked successor to the MIPS integer register file: DATA_W-bit entries, 2**ADDR_W deep, NUM_RD read ports, one write port.
- Adds a per-register busy scoreboard so the decode stage can detect RAW hazards against in-flight producers.
- Sits between decode (reads, reserve) and writeback (write, release).
- Register 0 reads as constant zero.

Parameters:
- DATA_W, 32, entry width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NUM_RD, 2, number of read ports (1..4)
- INIT_INDEX, 1, reset value: 1 -> entry i resets to i (register 0 still 0); 0 -> all entries reset to 0

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, port k at [k*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  busy bit of the addressed register, per port
- we  in  1  write enable (writeback)
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rsv_en  in  1  reserve request from decode
- rsv_addr  in  ADDR_W  destination register to mark busy
- busy_vec  out  DEPTH  full scoreboard, bit i = register i busy

Behaviour:
- Clock and reset: single clock domain. rst is sampled only on the rising clk edge, synchronous, active-high; it is the only reset.
- Reset: every entry loads its INIT_INDEX value and every busy bit clears.
  - During the rst cycle, we and rsv_en are ignored.
  - rd_busy and busy_vec read 0 from the first cycle after reset.
- Reads: combinational from the array, zero latency.
  - Address 0 always returns 0 with busy 0.
  - Read ports are fully independent; all may target the same address.
- Write: when we=1 and wr_addr!=0, the entry updates at the clock edge. Data is visible on rd_data the next cycle; the bypass below is not present without the macro.
  - A write to address 0 is discarded.
  - A write also clears the busy bit of wr_addr at the same edge.
- Reserve: when rsv_en=1 and rsv_addr!=0, busy[rsv_addr] is set at the edge. Reserving an already-busy register leaves it busy (no count; one producer in flight per register).
- Simultaneous events on the same edge:
  - we and rsv_en to the same non-zero address: reserve wins and the bit ends at 1, because the new producer supersedes. The data write still occurs.
  - we and rsv_en to different addresses: both take effect.
  - rst with either we or rsv_en: reset wins.
- Reset mid-operation: all outstanding reservations are discarded. A late writeback for a pre-reset reservation is an ordinary write and is not flagged.
- No X propagation: the array is fully reset, so no uninitialised reads after the first reset.

Optional Feature:
- REGFILE_BYPASS_EN defined: write-through bypass.
  - When we=1 and wr_addr!=0 matches rd_addr of port k in the same cycle, rd_data for port k = wr_data.
  - In that case rd_busy for port k = 0, unless rsv_en targets the same address in that cycle, in which case rd_busy = 1.
  - Register 0 is never bypassed.
- REGFILE_BYPASS_EN undefined: reads return stored array contents and the stored busy bit only; same-cycle writes are invisible until the next cycle.

Decomposition:
- Shared package regfile_pkg holds:
  - default constants REG_DATA_W=32, REG_ADDR_W=5, REG_ZERO_ADDR=0
  - the INIT_INDEX encoding constants
- One sub-module, regfile_read_port: a single read mux with zero-register forcing and the optional bypass compare, instantiated NUM_RD times in a generate loop.
- Scoreboard and array stay in the top module.

Test Plan:
- Reset then read:
  - rst=1 for 1 cycle, INIT_INDEX=1, rd_addr={7,0} -> rd_data={7,0}, busy_vec=0.
  - With INIT_INDEX=0, rd_addr=7 -> 0.
- Write/read latency: we=1, wr_addr=5, wr_data=32'hDEADBEEF.
  - Without macro: same-cycle read of 5 returns 5, next cycle returns DEADBEEF.
  - With macro: DEADBEEF in the same cycle.
- Register 0 protection: we=1, wr_addr=0, wr_data=32'hFFFFFFFF; rsv_en=1, rsv_addr=0 -> reads of 0 return 0, busy_vec[0]=0.
- Scoreboard lifecycle:
  - rsv_en to 9 -> busy_vec[9]=1 next cycle, and rd_busy=1 on a port reading 9.
  - Later we to 9 with data 32'h1234 -> busy_vec[9]=0 and rd_data=32'h1234 the following cycle.
- Collision: with busy[3]=1, same edge we to 3 (data 32'hA5) and rsv_en to 3 -> busy_vec[3]=1, rd_data(3)=32'hA5.
- Reset mid-flight: busy on registers 4 and 12, entry 4 = 32'h55, then rst=1 together with we to 4 -> busy_vec=0, entry 4 = 4 (INIT_INDEX=1).
